// File: rtl/mul_issue_ctrl.sv
// EX-stage issue/retire controller for the 3-cycle RV32M multiplier.
// Latches one multiply, stalls the front end while the multiplier runs,
// then presents the result and rd to EX/MEM for a single cycle.
module mul_issue_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_e,
  input  logic            is_mul_e,
  input  logic            kill_e,
  input  logic [2:0]      funct3_e,
  input  logic [XLEN-1:0] rs1_e,
  input  logic [XLEN-1:0] rs2_e,
  input  logic [4:0]      rd_e,
  output logic            mul_ce,
  output logic [2:0]      mul_funct3,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_result,
  output logic            stall_e,
  output logic            res_valid_m,
  output logic [XLEN-1:0] res_m,
  output logic [4:0]      rd_m
);

  localparam int unsigned CW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, load, capture;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;

  // Accept a multiply only from IDLE; reset is folded in so every output is
  // forced low while reset is asserted, even with valid_e high.
  always_comb begin
    accept = reset & (state == S_IDLE) & valid_e & is_mul_e & ~kill_e;
  end

  // Next-state, counter and control outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mul_ce   = 1'b0;
    stall_e  = 1'b0;
    load     = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          mul_ce   = 1'b1;
          stall_e  = 1'b1;
          load     = 1'b1;
          cnt_nx   = CW'(MUL_LATENCY - 1);
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        mul_ce = 1'b1;
        if (kill_e) begin
          state_nx = S_IDLE;
        end else begin
          stall_e = 1'b1;
          if (cnt == '0) begin
            capture  = 1'b1;
            state_nx = S_DONE;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
      end
      S_DONE: begin
        // Never accepts here: ID/EX still shows the retiring mul this cycle.
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands bypass straight from ID/EX in the accept cycle, then come from
  // the latched copies so ID/EX changes cannot disturb the multiplier.
  always_comb begin
    mul_a       = accept ? rs1_e    : a_q;
    mul_b       = accept ? rs2_e    : b_q;
    mul_funct3  = accept ? funct3_e : f3_q;
    res_valid_m = (state == S_DONE);
    res_m       = res_q;
    rd_m        = rd_q;
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Operand/rd latches on accept, result latch at end of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
    end else begin
      if (load) begin
        a_q  <= rs1_e;
        b_q  <= rs2_e;
        f3_q <= funct3_e;
        rd_q <= rd_e;
      end
      if (capture) begin
        res_q <= mul_result;
      end
    end
  end

endmodule
